// File: rtl/cmd_sequencer_pkg.sv
// cmd_sequencer_pkg: constants and types shared by the command sequencer.
//   seq_state_e  - sequencer FSM states
//   err_code_e   - err_code encodings (NONE / NACK / TIMEOUT / OVERFLOW)
//   POS_ACK      - RemoteComm positive acknowledge byte
//   OP_*         - opcode field values of a 16-bit command
package cmd_sequencer_pkg;

  localparam int CMD_W = 16;
  localparam int RSP_W = 8;
  localparam int TMO_W = 22;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_SENT = 2'd2,
    WAIT_RESP = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_NACK     = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_OVERFLOW = 2'b11
  } err_code_e;

  localparam logic [RSP_W-1:0] POS_ACK = 8'hA5;

  // command = {opcode[15:12], heading[11:4], squares[3:0]}
  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_CAL     = 4'h2;
  localparam logic [3:0] OP_MOVE    = 4'h4;
  localparam logic [3:0] OP_FANFARE = 4'h6;

  function automatic logic [3:0] cmd_opcode(input logic [CMD_W-1:0] c);
    return c[15:12];
  endfunction

endpackage

// File: rtl/cmd_sequencer_if.sv
// cmd_sequencer_if: link between the sequencer and RemoteComm.
//   cmd      - command word being sent (sequencer -> RemoteComm)
//   send_cmd - 1-clock request to transmit cmd
//   cmd_sent - RemoteComm finished transmitting
//   resp_rdy - response byte valid
//   resp     - response byte
// modport master: sequencer side; modport slave: RemoteComm side.
interface cmd_sequencer_if;
  import cmd_sequencer_pkg::*;

  logic [CMD_W-1:0] cmd;
  logic             send_cmd;
  logic             cmd_sent;
  logic             resp_rdy;
  logic [RSP_W-1:0] resp;

  modport master (output cmd, output send_cmd,
                  input  cmd_sent, input resp_rdy, input resp);
  modport slave  (input  cmd, input send_cmd,
                  output cmd_sent, output resp_rdy, output resp);
endinterface

// File: rtl/cmd_sequencer_fifo.sv
// cmd_fifo: DEPTH x 16 command FIFO with flush.
//   clk, rst      - clock, synchronous active-high reset
//   push, din     - enqueue din when not full and not flushing
//   pop, dout     - dequeue head (dout is the current head, first-word fall-through)
//   flush         - drop all contents; beats push and pop in the same cycle
//   full, empty   - status decoded from the occupancy count
module cmd_fifo
  import cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CMD_W-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [CMD_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
    wr_en    = push && !full && !flush;
    rd_en    = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queues 16-bit commands and issues them one at a time to
// RemoteComm, waiting for cmd_sent and then a response byte.
//   clk, rst          - clock, synchronous active-high reset
//   push, push_cmd    - enqueue a command
//   flush             - discard queued (not yet issued) commands
//   full, empty       - queue status
//   rc (master)       - cmd/send_cmd out, cmd_sent/resp_rdy/resp in
//   busy              - not IDLE
//   done, err         - 1-clock completion / failure pulses
//   err_code          - last error (00 none, 01 NACK, 10 TIMEOUT, 11 OVERFLOW)
//   ack_cnt           - count of positively acknowledged commands (wraps)
// Build option: define CMD_SEQ_RETRY_EN to re-issue a failed (NACK/TIMEOUT)
// command once before reporting err.
module cmd_sequencer
  import cmd_sequencer_pkg::*;
#(
  parameter int               DEPTH   = 4,
  parameter logic [TMO_W-1:0] TIMEOUT = 22'd3_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [CMD_W-1:0]  push_cmd,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  cmd_sequencer_if.master   rc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [7:0]        ack_cnt
);

  seq_state_e       state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             send_q, send_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  err_code_e        code_q, code_d;
  logic [7:0]       ack_q, ack_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             busy_q, busy_d;
  logic             retry_q, retry_d;

  logic             pop;
  logic [CMD_W-1:0] head;
  logic             fail;
  err_code_e        fail_code;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_cmd),
    .pop   (pop),
    .flush (flush),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign rc.cmd      = cmd_q;
  assign rc.send_cmd = send_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = code_q;
  assign ack_cnt     = ack_q;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    send_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    ack_d     = ack_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    pop       = 1'b0;
    fail      = 1'b0;
    fail_code = ERR_NONE;

    case (state_q)
      IDLE: begin
        // Popping on the IDLE->ISSUE edge lets send_cmd be registered
        // high during ISSUE, giving the 2-clock push-to-send latency.
        // A concurrent flush discards the head instead of issuing it.
        if (!empty && !flush) begin
          pop     = 1'b1;
          cmd_d   = head;
          send_d  = 1'b1;
          retry_d = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_SENT;
      WAIT_SENT: begin
        if (rc.cmd_sent) begin
          tmo_d   = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (rc.resp_rdy) begin
          if (rc.resp == POS_ACK) begin
            done_d  = 1'b1;
            ack_d   = ack_q + 8'd1;
            state_d = IDLE;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_NACK;
          end
        end else if (tmo_q == TIMEOUT - TMO_W'(1)) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail) begin
`ifdef CMD_SEQ_RETRY_EN
      // Re-send the held cmd once; only a second failure is reported.
      if (!retry_q) begin
        retry_d = 1'b1;
        send_d  = 1'b1;
        state_d = ISSUE;
      end else begin
        err_d   = 1'b1;
        code_d  = fail_code;
        state_d = IDLE;
      end
`else
      err_d   = 1'b1;
      code_d  = fail_code;
      state_d = IDLE;
`endif
    end

    // Dropped push; a push alongside flush is discarded silently.
    if (push && full && !flush) begin
      err_d  = 1'b1;
      code_d = ERR_OVERFLOW;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      ack_q   <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      send_q  <= send_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      retry_q <= retry_d;
    end
  end

endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4; command FIFO depth, power of 2, 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 22'd3_000_000; clocks allowed from cmd_sent to resp_rdy.
REQ-003 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port push  in  1  enqueue push_cmd this cycle.
REQ-006 SHALL have port push_cmd  in  16  command to enqueue (opcode[15:12], heading[11:4], squares[3:0]).
REQ-007 SHALL have port flush  in  1  discard all queued, not-yet-issued commands.
REQ-008 SHALL have ports full, empty  out  1 each  FIFO status.
REQ-009 SHALL have ports cmd  out  16 and send_cmd  out  1  drive RemoteComm.
REQ-010 SHALL have ports cmd_sent, resp_rdy  in  1 each and resp  in  8  from RemoteComm.
REQ-011 SHALL have ports busy  out  1, done  out  1 (pulse), err  out  1 (pulse), err_code  out  2, ack_cnt  out  8.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT_SENT, WAIT_RESP.
REQ-013 IDLE->ISSUE when !empty; ISSUE pops FIFO head into cmd and asserts send_cmd for exactly 1 clock, then ->WAIT_SENT.
REQ-014 cmd SHALL hold the issued value stable until the next ISSUE.
REQ-015 WAIT_SENT->WAIT_RESP on cmd_sent; timeout counter cleared on that transition.
REQ-016 In WAIT_RESP, resp_rdy with resp==8'hA5 SHALL pulse done 1 clock, increment ack_cnt (wraps 8'hFF->8'h00), ->IDLE.
REQ-017 In WAIT_RESP, resp_rdy with resp!=8'hA5 SHALL pulse err, err_code=2'b01 (NACK), ->IDLE.
REQ-018 In WAIT_RESP, counter reaching TIMEOUT-1 without resp_rdy SHALL pulse err, err_code=2'b10 (TIMEOUT), ->IDLE.
REQ-019 resp_rdy outside WAIT_RESP SHALL be ignored.
REQ-020 push while full SHALL be dropped, err pulse, err_code=2'b11 (OVERFLOW); FIFO unchanged, even if a pop occurs the same cycle.
REQ-021 push while !full with simultaneous pop SHALL both occur; count unchanged.
REQ-022 flush SHALL empty FIFO next cycle; in-flight command (WAIT_SENT/WAIT_RESP) SHALL complete normally; flush and push same cycle: flush wins, push dropped without error.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 err_code SHALL hold its last value until the next err pulse; 2'b00 means no error yet.
REQ-025 Minimum latency push to send_cmd on an idle empty block SHALL be 2 clocks.

Reset
REQ-026 rst SHALL force state IDLE, FIFO empty (empty=1, full=0), cmd=16'h0000, send_cmd=0, done=0, err=0, err_code=0, ack_cnt=0, busy=0, counter=0.
REQ-027 rst mid-operation SHALL abandon the in-flight command without done/err pulse.

Configuration
REQ-028 Macro CMD_SEQ_RETRY_EN: when defined, a NACK or TIMEOUT SHALL re-issue the same cmd once (back to ISSUE without popping); err pulses only if the retry also fails.
REQ-029 Without CMD_SEQ_RETRY_EN, each failure SHALL report err immediately, no re-issue.

Structure
REQ-030 Shared package SHALL hold the state enum, err_code enum, POS_ACK=8'hA5 and opcode constants.
REQ-031 FIFO SHALL be a separate sub-module cmd_fifo (DEPTH x 16, synchronous active-high rst, flush).

Verification
REQ-032 Push 16'h2000, responder acks 8'hA5 -> send_cmd 1-clock pulse with cmd=16'h2000, done pulse, ack_cnt=1.
REQ-033 Push 16'h4BF1, 16'h4002, 16'h6000 back-to-back -> issued in order, one send_cmd per command, ack_cnt=3, empty=1.
REQ-034 Push DEPTH+1 commands while stalled in WAIT_SENT -> full=1, last push dropped, err_code=2'b11.
REQ-035 Responder returns 8'h5A -> err pulse, err_code=2'b01; with CMD_SEQ_RETRY_EN, second send_cmd with same cmd first.
REQ-036 No resp_rdy after cmd_sent (TIMEOUT=100) -> err pulse exactly 100 clocks after cmd_sent, err_code=2'b10.
REQ-037 rst asserted in WAIT_RESP with 2 queued -> all outputs at reset values next clock, no done/err pulse.
